// File: rtl/rgb2bw_frame_ctrl.sv
// Frame sequencer around the combinational RGB-to-BW converter: reads RGB pixels,
// presents them to the converter, scales the result to 8-bit gray and writes it out.
module rgb2bw_frame_ctrl #(
   parameter int NUM_PIXELS = 16384,
   parameter int ADDR_W     = 14,
   parameter int GRAY_SHIFT = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic              src_rd_en,
   output logic [ADDR_W-1:0] src_addr,
   input  logic [23:0]       src_rd_data,
   output logic [7:0]        origi_red,
   output logic [7:0]        origi_green,
   output logic [7:0]        origi_blue,
   input  logic [14:0]       intmod_red,
   output logic              dst_wr_en,
   output logic [ADDR_W-1:0] dst_addr,
   output logic [7:0]        dst_wr_data,
   input  logic              dst_wr_ready,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [ADDR_W:0]   pix_count
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_CAP  = 3'd2;
   localparam logic [2:0] S_CONV = 3'd3;
   localparam logic [2:0] S_WR   = 3'd4;
   localparam logic [2:0] S_FIN  = 3'd5;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);

   logic [2:0]        state;
   logic [ADDR_W-1:0] index;
   logic              abort_lat;
   logic [14:0]       intmod_q;
   logic [14:0]       gray_full;

   // NOTE: every register below is updated with <= so all branches see the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         index       <= '0;
         abort_lat   <= 1'b0;
         intmod_q    <= '0;
         origi_red   <= '0;
         origi_green <= '0;
         origi_blue  <= '0;
         dst_addr    <= '0;
         pix_count   <= '0;
      end else begin
         // Abort is remembered from any active state; the WR branch below may override it.
         if (abort && state != S_IDLE && state != S_FIN)
            abort_lat <= 1'b1;

         case (state)
            S_IDLE: begin
               if (start) begin
                  index     <= '0;
                  pix_count <= '0;
                  abort_lat <= 1'b0;
                  state     <= S_RD;
               end
            end
            S_RD: state <= S_CAP;
            S_CAP: begin
               origi_red   <= src_rd_data[23:16];
               origi_green <= src_rd_data[15:8];
               origi_blue  <= src_rd_data[7:0];
               state       <= S_CONV;
            end
            S_CONV: begin
               intmod_q <= intmod_red;
               dst_addr <= index;
               state    <= S_WR;
            end
            S_WR: begin
               if (dst_wr_ready) begin
                  pix_count <= pix_count + 1'b1;
                  if (index == LAST_IDX) begin
                     // Completing the frame takes priority over a pending abort.
                     abort_lat <= 1'b0;
                     state     <= S_FIN;
                  end else if (abort_lat || abort) begin
                     abort_lat <= 1'b1;
                     state     <= S_FIN;
                  end else begin
                     index <= index + 1'b1;
                     state <= S_RD;
                  end
               end
            end
            S_FIN:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign gray_full   = intmod_q >> GRAY_SHIFT;
   assign dst_wr_data = (gray_full > 15'd255) ? 8'hFF : gray_full[7:0];

   assign src_addr  = index;
   assign src_rd_en = (state == S_RD);
   assign dst_wr_en = (state == S_WR);
   assign busy      = (state == S_RD) || (state == S_CAP) || (state == S_CONV) || (state == S_WR);
   assign done      = (state == S_FIN) && !abort_lat;
   assign aborted   = (state == S_FIN) && abort_lat;

endmodule

// File: tb/tb_rgb2bw_frame_ctrl.sv
// Self-checking bench for rgb2bw_frame_ctrl: random frames compared against a
// formula-level gray model, plus single-pixel, stall, abort and reset scenarios.
module tb_rgb2bw_frame_ctrl;

   localparam int N  = 256;
   localparam int AW = 8;
   localparam int SH = 7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic ready = 1'b1;
   always #5 clk = ~clk;

   // main instance
   logic          src_rd_en, dst_wr_en, busy, done, aborted;
   logic [AW-1:0] src_addr, dst_addr;
   logic [23:0]   src_rd_data = '0;
   logic [7:0]    o_r, o_g, o_b, dst_wr_data;
   logic [14:0]   intmod;
   logic [AW:0]   pix_count;

   // single-pixel instance, shift 6 so the white pixel needs saturation
   logic        start1 = 1'b0;
   logic        src_rd_en1, dst_wr_en1, busy1, done1, aborted1;
   logic [0:0]  src_addr1, dst_addr1;
   logic [7:0]  o1_r, o1_g, o1_b, dst_wr_data1;
   logic [14:0] intmod1;
   logic [1:0]  pix_count1;

   rgb2bw_frame_ctrl #(.NUM_PIXELS(N), .ADDR_W(AW), .GRAY_SHIFT(SH)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .src_rd_en(src_rd_en), .src_addr(src_addr), .src_rd_data(src_rd_data),
      .origi_red(o_r), .origi_green(o_g), .origi_blue(o_b), .intmod_red(intmod),
      .dst_wr_en(dst_wr_en), .dst_addr(dst_addr), .dst_wr_data(dst_wr_data),
      .dst_wr_ready(ready), .busy(busy), .done(done), .aborted(aborted),
      .pix_count(pix_count)
   );

   rgb2bw_frame_ctrl #(.NUM_PIXELS(1), .ADDR_W(1), .GRAY_SHIFT(6)) u_one (
      .clk(clk), .rst(rst), .start(start1), .abort(1'b0),
      .src_rd_en(src_rd_en1), .src_addr(src_addr1), .src_rd_data(24'hFFFFFF),
      .origi_red(o1_r), .origi_green(o1_g), .origi_blue(o1_b), .intmod_red(intmod1),
      .dst_wr_en(dst_wr_en1), .dst_addr(dst_addr1), .dst_wr_data(dst_wr_data1),
      .dst_wr_ready(1'b1), .busy(busy1), .done(done1), .aborted(aborted1),
      .pix_count(pix_count1)
   );

   // Converter behaviour: weights 38/75/15, summing to 128.
   function automatic logic [14:0] conv(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      int s;
      s = 38 * int'(r) + 75 * int'(g) + 15 * int'(b);
      return 15'(s);
   endfunction

   // Reference gray value straight from the pixel.
   function automatic logic [7:0] ref_gray(input logic [23:0] p, input int sh);
      int s;
      s = (38 * int'(p[23:16]) + 75 * int'(p[15:8]) + 15 * int'(p[7:0])) >> sh;
      return (s > 255) ? 8'd255 : 8'(s);
   endfunction

   always_comb intmod  = conv(o_r, o_g, o_b);
   always_comb intmod1 = conv(o1_r, o1_g, o1_b);

   logic [23:0] src_mem [N];
   always @(posedge clk) if (src_rd_en) src_rd_data <= src_mem[src_addr];

   // Observers
   logic [AW-1:0] wr_addr_q [$];
   logic [7:0]    wr_data_q [$];
   logic [AW-1:0] rd_q [$];
   int done_cnt = 0, abort_cnt = 0;
   int w1_cnt = 0, r1_cnt = 0, done1_cnt = 0, abort1_cnt = 0;
   logic [7:0] w1_data = '0;
   logic       s1_addr_bad = 1'b0;

   always @(posedge clk) begin
      if (dst_wr_en && ready) begin
         wr_addr_q.push_back(dst_addr);
         wr_data_q.push_back(dst_wr_data);
      end
      if (src_rd_en) rd_q.push_back(src_addr);
      if (done)      done_cnt  <= done_cnt + 1;
      if (aborted)   abort_cnt <= abort_cnt + 1;
      if (dst_wr_en1) begin
         w1_cnt  <= w1_cnt + 1;
         w1_data <= dst_wr_data1;
      end
      if (src_rd_en1) r1_cnt <= r1_cnt + 1;
      if ((src_rd_en1 && src_addr1 != 1'b0) || (dst_wr_en1 && dst_addr1 != 1'b0)) s1_addr_bad <= 1'b1;
      if (done1)     done1_cnt  <= done1_cnt + 1;
      if (aborted1 || busy1 === 1'bx) abort1_cnt <= abort1_cnt + 1;
   end

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // kind 0: done/aborted, 1: read of address a, 2: write of address a
   task automatic wait_ev(input int kind, input int a, input int limit, inout int cyc, input string tag);
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < limit && !hit; k++) begin
         @(negedge clk);
         cyc++;
         case (kind)
            0:       hit = done || aborted;
            1:       hit = src_rd_en && int'(src_addr) == a;
            default: hit = dst_wr_en && int'(dst_addr) == a;
         endcase
      end
      check({tag, "_reached"}, 32'(hit), 32'd1);
   endtask

   task automatic start_frame(input bit with_abort, output int cyc);
      start = 1'b1;
      abort = with_abort;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      cyc = 1;
   endtask

   task automatic randomize_src();
      for (int i = 0; i < N; i++) src_mem[i] = 24'($urandom);
      src_mem[0] = 24'hFFFFFF;
      src_mem[1] = 24'h000000;
   endtask

   task automatic check_frame(input int wb, input int rb, input int n, input string tag);
      int mx;
      check({tag, "_wr_count"}, 32'(wr_addr_q.size() - wb), 32'(n));
      check({tag, "_rd_count"}, 32'(rd_q.size() - rb), 32'(n));
      mx = -1;
      for (int i = rb; i < rd_q.size(); i++) if (int'(rd_q[i]) > mx) mx = int'(rd_q[i]);
      check({tag, "_rd_max"}, 32'(mx), 32'(n - 1));
      for (int i = 0; i < n && wb + i < wr_addr_q.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[wb + i]), 32'(i));
         check($sformatf("%s_data%0d", tag, i), 32'(wr_data_q[wb + i]), 32'(ref_gray(src_mem[i], SH)));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, wb, rb, dc, ac, rcnt;
      bit stable;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_aborted", 32'(aborted), 0);
      check("rst_rd_en", 32'(src_rd_en), 0);
      check("rst_wr_en", 32'(dst_wr_en), 0);
      check("rst_src_addr", 32'(src_addr), 0);
      check("rst_dst_addr", 32'(dst_addr), 0);
      check("rst_wr_data", 32'(dst_wr_data), 0);
      check("rst_origi_red", 32'(o_r), 0);
      check("rst_pix_count", 32'(pix_count), 0);
      rst = 1'b0;
      @(negedge clk);

      // Single-pixel frame on the one-pixel instance
      start1 = 1'b1;
      cyc = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         start1 = 1'b0;
         if (done1 && cyc < 0) cyc = k;
      end
      check("one_latency", 32'(cyc), 32'd5);
      check("one_data", 32'(w1_data), 32'(ref_gray(24'hFFFFFF, 6)));
      check("one_writes", 32'(w1_cnt), 1);
      check("one_reads", 32'(r1_cnt), 1);
      check("one_pix_count", 32'(pix_count1), 1);
      check("one_done_pulses", 32'(done1_cnt), 1);
      check("one_aborted", 32'(abort1_cnt), 0);
      check("one_addr", 32'(s1_addr_bad), 0);

      // Full random frame; a second start mid-frame must be ignored
      randomize_src();
      wb = wr_addr_q.size();
      rb = rd_q.size();
      start_frame(1'b0, cyc);
      repeat (19) begin @(negedge clk); cyc++; end
      start = 1'b1;
      @(negedge clk);
      cyc++;
      start = 1'b0;
      wait_ev(0, 0, 2000, cyc, "f1");
      check("f1_latency", 32'(cyc), 32'(4 * N + 1));
      check("f1_done", 32'(done), 1);
      check("f1_busy_at_done", 32'(busy), 0);
      check("f1_aborted", 32'(aborted), 0);
      check("f1_pix_count", 32'(pix_count), 32'(N));
      check_frame(wb, rb, N, "f1");
      @(negedge clk);
      check("f1_done_one_cycle", 32'(done), 0);

      // Abort while idle is ignored
      ac = abort_cnt;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_abort_busy", 32'(busy), 0);
      check("idle_abort_pix_count", 32'(pix_count), 32'(N));
      check("idle_abort_pulse", 32'(abort_cnt - ac), 0);
      check("idle_abort_writes", 32'(wr_addr_q.size() - wb), 32'(N));

      // Start with coincident abort, backpressure at pixel 3
      randomize_src();
      wb = wr_addr_q.size();
      rb = rd_q.size();
      ac = abort_cnt;
      dc = done_cnt;
      start_frame(1'b1, cyc);
      wait_ev(2, 3, 100, cyc, "bp_wr3");
      ready = 1'b0;
      rcnt = rd_q.size();
      stable = 1'b1;
      repeat (10) begin
         @(negedge clk);
         cyc++;
         stable &= dst_wr_en && dst_addr == AW'(3) && dst_wr_data == ref_gray(src_mem[3], SH) && !src_rd_en;
      end
      ready = 1'b1;
      check("bp_stable", 32'(stable), 1);
      check("bp_no_reads", 32'(rd_q.size() - rcnt), 0);
      wait_ev(0, 0, 2000, cyc, "bp");
      check("bp_latency", 32'(cyc), 32'(4 * N + 1 + 10));
      check("bp_done", 32'(done), 1);
      check("bp_no_abort", 32'(abort_cnt - ac), 0);
      check_frame(wb, rb, N, "bp");

      // Abort during CAP of pixel 100
      randomize_src();
      @(negedge clk);
      wb = wr_addr_q.size();
      rb = rd_q.size();
      dc = done_cnt;
      start_frame(1'b0, cyc);
      wait_ev(1, 100, 1000, cyc, "ab_rd100");
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_ev(0, 0, 100, cyc, "ab");
      check("ab_aborted", 32'(aborted), 1);
      check("ab_done", 32'(done), 0);
      check("ab_busy", 32'(busy), 0);
      check("ab_pix_count", 32'(pix_count), 101);
      check_frame(wb, rb, 101, "ab");
      repeat (2) @(negedge clk);
      check("ab_no_done", 32'(done_cnt - dc), 0);

      // Reset during WR of pixel 50, then restart
      wb = wr_addr_q.size();
      dc = done_cnt;
      ac = abort_cnt;
      start_frame(1'b0, cyc);
      wait_ev(2, 50, 1000, cyc, "rs_wr50");
      ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("rs_busy", 32'(busy), 0);
      check("rs_wr_en", 32'(dst_wr_en), 0);
      check("rs_rd_en", 32'(src_rd_en), 0);
      check("rs_dst_addr", 32'(dst_addr), 0);
      check("rs_src_addr", 32'(src_addr), 0);
      check("rs_pix_count", 32'(pix_count), 0);
      check("rs_origi", 32'({o_r, o_g, o_b}), 0);
      check("rs_writes", 32'(wr_addr_q.size() - wb), 50);
      rst = 1'b0;
      ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rs_no_pulses", 32'((done_cnt - dc) + (abort_cnt - ac)), 0);
      wb = wr_addr_q.size();
      rb = rd_q.size();
      start_frame(1'b0, cyc);
      check("rs_restart_addr", 32'(src_addr), 0);
      check("rs_restart_rd", 32'(src_rd_en), 1);
      wait_ev(0, 0, 2000, cyc, "rs");
      check("rs_latency", 32'(cyc), 32'(4 * N + 1));
      check("rs_done", 32'(done), 1);
      check_frame(wb, rb, N, "rs");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
